// File: rtl/rtmq_fifo_bram.sv
// RTMQ register-bus FIFO peripheral: write ADDR to push, read ADDR as an operand to pop,
// read ADDR_STA for occupancy plus clear-on-read overflow/underflow flags.
module rtmq_fifo_bram #(
  parameter int ADDR     = 0,
  parameter int ADDR_STA = 1,
  parameter int N_DPT    = 16,
  parameter int W_PTR    = 4,
  parameter int W_ADR    = 8,
  parameter int W_REG    = 32,
  parameter int W_ALU    = W_REG + 3 * W_ADR + 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W_ALU-1:0] alu_out,
  output logic [W_REG-1:0] fifo_out,
  output logic [W_REG-1:0] sta_out
);

  localparam int W_CNT = W_PTR + 1;
  localparam logic [W_ADR-1:0] ADR_DAT = W_ADR'(ADDR);
  localparam logic [W_ADR-1:0] ADR_STA = W_ADR'(ADDR_STA);
  localparam logic [W_CNT-1:0] CNT_FULL = W_CNT'(N_DPT);
  localparam logic [W_CNT-1:0] CNT_ZERO = W_CNT'(0);

  // Bus layout, LSB first: result, RD address, operand A, operand B, RD enable, A valid, B valid.
  logic [W_REG-1:0] bus_res;
  logic [W_ADR-1:0] bus_rd_adr, bus_opa_adr, bus_opb_adr;
  logic             bus_rd_en, bus_opa_vld, bus_opb_vld;

  assign bus_res     = alu_out[W_REG-1:0];
  assign bus_rd_adr  = alu_out[W_REG +: W_ADR];
  assign bus_opa_adr = alu_out[W_REG + W_ADR +: W_ADR];
  assign bus_opb_adr = alu_out[W_REG + 2 * W_ADR +: W_ADR];
  assign bus_rd_en   = alu_out[W_REG + 3 * W_ADR];
  assign bus_opa_vld = alu_out[W_REG + 3 * W_ADR + 1];
  assign bus_opb_vld = alu_out[W_REG + 3 * W_ADR + 2];

  logic [W_REG-1:0] mem [N_DPT];

  logic             f_pop_d, f_pop_q, f_psh_d, f_psh_q, f_sta_d, f_sta_q;
  logic [W_REG-1:0] d_psh_d, d_psh_q;
  logic [W_PTR-1:0] rd_ptr_d, rd_ptr_q, wr_ptr_d, wr_ptr_q;
  logic [W_CNT-1:0] cnt_d, cnt_q;
  logic             ovf_d, ovf_q, udf_d, udf_q;
  logic [W_REG-1:0] fifo_out_d, fifo_out_q, sta_out_d, sta_out_q;
  logic             pop_ok, psh_ok;

  always_comb begin
    f_pop_d = (bus_opa_vld && (bus_opa_adr == ADR_DAT)) ||
              (bus_opb_vld && (bus_opb_adr == ADR_DAT));
    f_sta_d = (bus_opa_vld && (bus_opa_adr == ADR_STA)) ||
              (bus_opb_vld && (bus_opb_adr == ADR_STA));
    f_psh_d = bus_rd_en && (bus_rd_adr == ADR_DAT);
    if (f_psh_d) begin
      d_psh_d = bus_res;
    end else begin
      d_psh_d = d_psh_q;
    end
  end

  always_comb begin
    pop_ok   = f_pop_q && (cnt_q != CNT_ZERO);
    // A full queue still accepts a push when a pop frees a slot in the same cycle.
    psh_ok   = f_psh_q && ((cnt_q != CNT_FULL) || pop_ok);
    rd_ptr_d = rd_ptr_q + W_PTR'(pop_ok);
    wr_ptr_d = wr_ptr_q + W_PTR'(psh_ok);
    cnt_d    = cnt_q + W_CNT'(psh_ok) - W_CNT'(pop_ok);

    if (f_psh_q && !psh_ok) begin
      ovf_d = 1'b1;
    end else if (f_sta_q) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (f_pop_q && (cnt_q == CNT_ZERO)) begin
      udf_d = 1'b1;
    end else if (f_sta_q) begin
      udf_d = 1'b0;
    end else begin
      udf_d = udf_q;
    end

    // The word being written this cycle becomes the head when it lands at the next read slot.
    if (cnt_d == CNT_ZERO) begin
      fifo_out_d = '0;
    end else if (psh_ok && (wr_ptr_q == rd_ptr_d)) begin
      fifo_out_d = d_psh_q;
    end else begin
      fifo_out_d = mem[rd_ptr_d];
    end

    sta_out_d            = '0;
    sta_out_d[W_CNT-1:0] = cnt_d;
    sta_out_d[16]        = (cnt_d == CNT_ZERO);
    sta_out_d[17]        = (cnt_d == CNT_FULL);
    sta_out_d[18]        = ovf_d;
    sta_out_d[19]        = udf_d;
  end

  always_ff @(posedge clk) begin
    if (!rst && psh_ok) begin
      mem[wr_ptr_q] <= d_psh_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_pop_q    <= 1'b0;
      f_psh_q    <= 1'b0;
      f_sta_q    <= 1'b0;
      d_psh_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      fifo_out_q <= '0;
      sta_out_q  <= W_REG'(32'h0001_0000);
    end else begin
      f_pop_q    <= f_pop_d;
      f_psh_q    <= f_psh_d;
      f_sta_q    <= f_sta_d;
      d_psh_q    <= d_psh_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      fifo_out_q <= fifo_out_d;
      sta_out_q  <= sta_out_d;
    end
  end

  assign fifo_out = fifo_out_q;
  assign sta_out  = sta_out_q;

endmodule
